// File: rtl/linkup_pkg.sv
// Shared state encodings and parameter defaults for the link-up sequencer.
package linkup_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PULSE   = 3'd1,
        ST_GAP     = 3'd2,
        ST_UP      = 3'd3,
        ST_RECOVER = 3'd4,
        ST_FAULT   = 3'd5
    } state_t;

    localparam int PULSE_W_DEF   = 4;
    localparam int GAP_W_DEF     = 16;
    localparam int RST_W_DEF     = 8;
    localparam int MAX_RETRY_DEF = 3;
    localparam int CNT_W         = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
module sync_2ff (
    input  logic i_Clk,
    input  logic i_Rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: sequential state uses <= so both flops sample pre-edge values and form a real 2-stage chain.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/linkup_seq_ctrl.sv
// Link bring-up sequencer: pulses the link-up enable, watches for link/timeout,
// resets the remote device on failure and gives up after MAX_RETRY recoveries.
module linkup_seq_ctrl
    import linkup_pkg::*;
#(
    parameter int PULSE_W   = PULSE_W_DEF,
    parameter int GAP_W     = GAP_W_DEF,
    parameter int RST_W     = RST_W_DEF,
    parameter int MAX_RETRY = MAX_RETRY_DEF
) (
    input  logic       i_Clk,
    input  logic       i_Rst_n,
    input  logic       i_Start,
    input  logic       i_ich_linkup,
    input  logic       i_TimeOut,
    output logic       o_LinkUp_En,
    output logic       o_Clear_TimeOut,
    output logic       o_Remote_Rst_n,
    output logic       o_Link_Ok,
    output logic       o_Fault,
    output logic [1:0] o_Retry_Cnt,
    output logic [2:0] o_State
);

    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_W - 1);
    localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_W - 1);
    localparam logic [1:0]       RETRY_MAX  = 2'(MAX_RETRY);

    state_t           state;
    logic [CNT_W-1:0] phase_cnt;
    logic             lk;
    logic [1:0]       retry_inc;

    sync_2ff u_sync_linkup (
        .i_Clk   (i_Clk),
        .i_Rst_n (i_Rst_n),
        .d       (i_ich_linkup),
        .q       (lk)
    );

    // NOTE: every always_comb output gets an unconditional assignment so no latch is inferred.
    always_comb begin
        retry_inc = o_Retry_Cnt;
        if (o_Retry_Cnt != RETRY_MAX) retry_inc = o_Retry_Cnt + 2'd1;
    end

    assign o_State = state;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state           <= ST_IDLE;
            phase_cnt       <= '0;
            o_LinkUp_En     <= 1'b0;
            o_Clear_TimeOut <= 1'b0;
            o_Remote_Rst_n  <= 1'b1;
            o_Link_Ok       <= 1'b0;
            o_Fault         <= 1'b0;
            o_Retry_Cnt     <= 2'd0;
        end else begin
            o_Clear_TimeOut <= 1'b0;
            // Dropping i_Start overrides everything, including a reset in progress.
            if (!i_Start) begin
                state          <= ST_IDLE;
                phase_cnt      <= '0;
                o_LinkUp_En    <= 1'b0;
                o_Remote_Rst_n <= 1'b1;
                o_Link_Ok      <= 1'b0;
                o_Fault        <= 1'b0;
                o_Retry_Cnt    <= 2'd0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state       <= ST_PULSE;
                        phase_cnt   <= '0;
                        o_Retry_Cnt <= 2'd0;
                        o_LinkUp_En <= 1'b1;
                    end
                    ST_PULSE, ST_GAP: begin
                        if (lk) begin
                            state           <= ST_UP;
                            phase_cnt       <= '0;
                            o_LinkUp_En     <= 1'b0;
                            o_Link_Ok       <= 1'b1;
                            o_Clear_TimeOut <= 1'b1;
                        end else if (i_TimeOut) begin
                            state           <= ST_RECOVER;
                            phase_cnt       <= '0;
                            o_LinkUp_En     <= 1'b0;
                            o_Remote_Rst_n  <= 1'b0;
                            o_Clear_TimeOut <= 1'b1;
                        end else if (state == ST_PULSE && phase_cnt == PULSE_LAST) begin
                            state       <= ST_GAP;
                            phase_cnt   <= '0;
                            o_LinkUp_En <= 1'b0;
                        end else if (state == ST_GAP && phase_cnt == GAP_LAST) begin
                            state       <= ST_PULSE;
                            phase_cnt   <= '0;
                            o_LinkUp_En <= 1'b1;
                        end else begin
                            phase_cnt <= phase_cnt + 1'b1;
                        end
                    end
                    ST_UP: begin
                        if (!lk) begin
                            state           <= ST_RECOVER;
                            phase_cnt       <= '0;
                            o_Link_Ok       <= 1'b0;
                            o_Remote_Rst_n  <= 1'b0;
                            o_Clear_TimeOut <= 1'b1;
                        end
                    end
                    ST_RECOVER: begin
                        if (phase_cnt == RST_LAST) begin
                            phase_cnt      <= '0;
                            o_Remote_Rst_n <= 1'b1;
                            o_Retry_Cnt    <= retry_inc;
                            if (retry_inc == RETRY_MAX) begin
                                state   <= ST_FAULT;
                                o_Fault <= 1'b1;
                            end else begin
                                state       <= ST_PULSE;
                                o_LinkUp_En <= 1'b1;
                            end
                        end else begin
                            phase_cnt <= phase_cnt + 1'b1;
                        end
                    end
                    ST_FAULT: begin
                        o_Fault <= 1'b1;
                    end
                    default: begin
                        state     <= ST_IDLE;
                        phase_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_linkup_seq_ctrl.sv
// Directed bench for linkup_seq_ctrl at default parameters (4/16/8/3).
module tb_linkup_seq_ctrl;
    import linkup_pkg::*;

    logic       i_Clk;
    logic       i_Rst_n;
    logic       i_Start;
    logic       i_ich_linkup;
    logic       i_TimeOut;
    logic       o_LinkUp_En;
    logic       o_Clear_TimeOut;
    logic       o_Remote_Rst_n;
    logic       o_Link_Ok;
    logic       o_Fault;
    logic [1:0] o_Retry_Cnt;
    logic [2:0] o_State;

    int total = 0;
    int bad   = 0;

    linkup_seq_ctrl dut (
        .i_Clk           (i_Clk),
        .i_Rst_n         (i_Rst_n),
        .i_Start         (i_Start),
        .i_ich_linkup    (i_ich_linkup),
        .i_TimeOut       (i_TimeOut),
        .o_LinkUp_En     (o_LinkUp_En),
        .o_Clear_TimeOut (o_Clear_TimeOut),
        .o_Remote_Rst_n  (o_Remote_Rst_n),
        .o_Link_Ok       (o_Link_Ok),
        .o_Fault         (o_Fault),
        .o_Retry_Cnt     (o_Retry_Cnt),
        .o_State         (o_State)
    );

    initial begin
        i_Clk = 1'b0;
        forever #5 i_Clk = ~i_Clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".state"}, 8'(o_State), 8'(ST_IDLE));
        check({tag, ".en"},    8'(o_LinkUp_En), 8'd0);
        check({tag, ".clr"},   8'(o_Clear_TimeOut), 8'd0);
        check({tag, ".rrst"},  8'(o_Remote_Rst_n), 8'd1);
        check({tag, ".ok"},    8'(o_Link_Ok), 8'd0);
        check({tag, ".fault"}, 8'(o_Fault), 8'd0);
        check({tag, ".retry"}, 8'(o_Retry_Cnt), 8'd0);
    endtask

    // Remaining 7 low cycles of a recovery, then the exit edge.
    task automatic finish_recover(input string tag, input state_t exp_st, input logic [1:0] exp_retry);
        for (int i = 0; i < 7; i++) begin
            tick();
            check({tag, ".rec_st"}, 8'(o_State), 8'(ST_RECOVER));
            check({tag, ".rrst_lo"}, 8'(o_Remote_Rst_n), 8'd0);
            check({tag, ".clr_once"}, 8'(o_Clear_TimeOut), 8'd0);
        end
        tick();
        check({tag, ".exit_st"}, 8'(o_State), 8'(exp_st));
        check({tag, ".rrst_hi"}, 8'(o_Remote_Rst_n), 8'd1);
        check({tag, ".retry"}, 8'(o_Retry_Cnt), 8'(exp_retry));
        check({tag, ".en"}, 8'(o_LinkUp_En), (exp_st == ST_PULSE) ? 8'd1 : 8'd0);
        check({tag, ".fault"}, 8'(o_Fault), (exp_st == ST_FAULT) ? 8'd1 : 8'd0);
    endtask

    task automatic timeout_recover(input string tag, input state_t exp_st, input logic [1:0] exp_retry);
        i_TimeOut = 1'b1;
        tick();
        check({tag, ".entry_st"}, 8'(o_State), 8'(ST_RECOVER));
        check({tag, ".entry_clr"}, 8'(o_Clear_TimeOut), 8'd1);
        check({tag, ".entry_rrst"}, 8'(o_Remote_Rst_n), 8'd0);
        check({tag, ".entry_en"}, 8'(o_LinkUp_En), 8'd0);
        i_TimeOut = 1'b0;
        finish_recover(tag, exp_st, exp_retry);
    endtask

    initial begin
        i_Rst_n      = 1'b0;
        i_Start      = 1'b0;
        i_ich_linkup = 1'b0;
        i_TimeOut    = 1'b0;

        // Reset held with random inputs
        for (int i = 0; i < 4; i++) begin
            i_Start      = 1'($urandom);
            i_ich_linkup = 1'($urandom);
            i_TimeOut    = 1'($urandom);
            tick();
            check_idle("rst_hold");
        end
        i_Start      = 1'b0;
        i_ich_linkup = 1'b0;
        i_TimeOut    = 1'b0;
        i_Rst_n      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_idle("rst_release");
        end

        // Normal link-up: two PULSE/GAP rounds, link rises in the 2nd GAP
        i_Start = 1'b1;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) begin
                tick();
                check("pulse_st", 8'(o_State), 8'(ST_PULSE));
                check("pulse_en", 8'(o_LinkUp_En), 8'd1);
            end
            for (int i = 0; i < ((r == 0) ? 16 : 5); i++) begin
                tick();
                check("gap_st", 8'(o_State), 8'(ST_GAP));
                check("gap_en", 8'(o_LinkUp_En), 8'd0);
            end
        end
        i_ich_linkup = 1'b1;
        tick();
        check("lk_edge1_ok", 8'(o_Link_Ok), 8'd0);
        tick();
        check("lk_edge2_ok", 8'(o_Link_Ok), 8'd0);
        check("lk_edge2_st", 8'(o_State), 8'(ST_GAP));
        tick();
        check("lk_edge3_ok", 8'(o_Link_Ok), 8'd1);
        check("lk_edge3_st", 8'(o_State), 8'(ST_UP));
        check("lk_edge3_clr", 8'(o_Clear_TimeOut), 8'd1);
        check("lk_edge3_en", 8'(o_LinkUp_En), 8'd0);
        tick();
        check("up_clr_once", 8'(o_Clear_TimeOut), 8'd0);
        check("up_ok_hold", 8'(o_Link_Ok), 8'd1);
        i_Start      = 1'b0;
        i_ich_linkup = 1'b0;
        tick();
        check_idle("up_abort");
        tick();
        tick();

        // One recovery after a timeout in PULSE
        i_Start = 1'b1;
        tick();
        check("rec1_pulse", 8'(o_State), 8'(ST_PULSE));
        timeout_recover("rec1", ST_PULSE, 2'd1);

        // Two more consecutive timeouts reach FAULT
        timeout_recover("rec2", ST_PULSE, 2'd2);
        timeout_recover("rec3", ST_FAULT, 2'd3);
        i_TimeOut = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("fault_st", 8'(o_State), 8'(ST_FAULT));
            check("fault_flag", 8'(o_Fault), 8'd1);
            check("fault_en", 8'(o_LinkUp_En), 8'd0);
            check("fault_retry", 8'(o_Retry_Cnt), 8'd3);
            check("fault_clr", 8'(o_Clear_TimeOut), 8'd0);
        end
        i_TimeOut = 1'b0;
        i_Start   = 1'b0;
        tick();
        check_idle("fault_exit");

        // lk and timeout together: UP wins; then link loss recovers
        i_Start = 1'b1;
        tick();
        check("sim_pulse", 8'(o_State), 8'(ST_PULSE));
        i_ich_linkup = 1'b1;
        tick();
        tick();
        i_TimeOut = 1'b1;
        tick();
        check("sim_st", 8'(o_State), 8'(ST_UP));
        check("sim_clr", 8'(o_Clear_TimeOut), 8'd1);
        check("sim_rrst", 8'(o_Remote_Rst_n), 8'd1);
        i_TimeOut = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("sim_up_hold", 8'(o_State), 8'(ST_UP));
            check("sim_up_retry", 8'(o_Retry_Cnt), 8'd0);
        end
        i_ich_linkup = 1'b0;
        tick();
        check("loss_edge1", 8'(o_State), 8'(ST_UP));
        tick();
        check("loss_edge2", 8'(o_State), 8'(ST_UP));
        tick();
        check("loss_st", 8'(o_State), 8'(ST_RECOVER));
        check("loss_clr", 8'(o_Clear_TimeOut), 8'd1);
        check("loss_ok", 8'(o_Link_Ok), 8'd0);
        check("loss_rrst", 8'(o_Remote_Rst_n), 8'd0);
        finish_recover("loss", ST_PULSE, 2'd1);

        // Abort on cycle 4 of RECOVER
        i_TimeOut = 1'b1;
        tick();
        i_TimeOut = 1'b0;
        tick();
        tick();
        tick();
        check("abort_c4_st", 8'(o_State), 8'(ST_RECOVER));
        check("abort_c4_rrst", 8'(o_Remote_Rst_n), 8'd0);
        i_Start = 1'b0;
        tick();
        check_idle("abort");

        // Reset asserted mid-PULSE, then a clean restart
        i_Start = 1'b1;
        tick();
        tick();
        check("midrst_pulse", 8'(o_State), 8'(ST_PULSE));
        i_Rst_n = 1'b0;
        #1;
        check_idle("midrst_async");
        #2;
        i_Rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("restart_st", 8'(o_State), 8'(ST_PULSE));
            check("restart_clr", 8'(o_Clear_TimeOut), 8'd0);
        end
        tick();
        check("restart_gap", 8'(o_State), 8'(ST_GAP));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/linkup_seq_ctrl.md
LINKUP_SEQ_CTRL -- requirements
Module: linkup_seq_ctrl

Interface
REQ-001 SHALL have parameter PULSE_W, default 4, meaning cycles o_LinkUp_En is held high per attempt (legal range 2..255).
REQ-002 SHALL have parameter GAP_W, default 16, meaning cycles o_LinkUp_En is held low between attempts (legal range 1..255).
REQ-003 SHALL have parameter RST_W, default 8, meaning cycles o_Remote_Rst_n is held low per recovery (legal range 1..255).
REQ-004 SHALL have parameter MAX_RETRY, default 3, meaning recoveries allowed before fault (legal range 1..3).
REQ-005 SHALL have port i_Clk, input, 1, meaning the single clock.
REQ-006 SHALL have port i_Rst_n, input, 1, meaning the reset: asynchronous, active-low.
REQ-007 SHALL have port i_Start, input, 1, meaning level enable for link bring-up; low forces IDLE.
REQ-008 SHALL have port i_ich_linkup, input, 1, meaning asynchronous link-up status from the remote device.
REQ-009 SHALL have port i_TimeOut, input, 1, meaning the sticky flag from the link-up timeout detector.
REQ-010 SHALL have port o_LinkUp_En, output, 1, meaning the attempt enable driven to the timeout detector and to the remote device.
REQ-011 SHALL have port o_Clear_TimeOut, output, 1, meaning a one-cycle pulse that clears the timeout detector.
REQ-012 SHALL have port o_Remote_Rst_n, output, 1, meaning an active-low reset to the remote device.
REQ-013 SHALL have port o_Link_Ok, output, 1, meaning the link is up.
REQ-014 SHALL have port o_Fault, output, 1, meaning retries are exhausted.
REQ-015 SHALL have port o_Retry_Cnt, output, 2, meaning the number of recoveries done in the current session.
REQ-016 SHALL have port o_State, output, 3, meaning the current state encoding, for debug.

Function
REQ-017 SHALL pass i_ich_linkup through a 2-flop synchronizer and use only the synchronized value (lk).
REQ-018 SHALL implement states IDLE, PULSE, GAP, UP, RECOVER and FAULT, one-hot or binary, encoded per the package.
REQ-019 SHALL, in IDLE, move to PULSE when i_Start=1 and clear o_Retry_Cnt and the phase counter.
REQ-020 SHALL, in PULSE, drive o_LinkUp_En=1 and go to GAP after exactly PULSE_W cycles; in GAP, drive it 0 and go to PULSE after exactly GAP_W cycles.
REQ-021 SHALL, in PULSE or GAP, go to UP when lk=1, and otherwise go to RECOVER when i_TimeOut=1; when both are set in the same cycle, UP wins.
REQ-022 SHALL, in UP, hold o_Link_Ok=1 and o_LinkUp_En=0, and go to RECOVER when lk falls to 0.
REQ-023 SHALL, in RECOVER, hold o_Remote_Rst_n=0 for exactly RST_W cycles and then increment o_Retry_Cnt.
REQ-024 SHALL, at the end of RECOVER, go to FAULT if the incremented count equals MAX_RETRY, else to PULSE.
REQ-025 SHALL assert o_Clear_TimeOut for exactly one cycle on every entry to UP and on every entry to RECOVER.
REQ-026 SHALL, in FAULT, hold o_Fault=1 and all other outputs at their idle values, and leave FAULT only when i_Start=0.
REQ-027 SHALL, from any state, go to IDLE on the next edge when i_Start=0; this has top priority and abandons any RECOVER in progress (o_Remote_Rst_n returns to 1).
REQ-028 SHALL register all outputs, and o_Link_Ok SHALL rise on the 3rd rising edge after i_ich_linkup rises (2 sync + 1 state).
REQ-029 SHALL make o_Retry_Cnt saturate at MAX_RETRY and never wrap; it holds its value in UP.

Reset
REQ-030 SHALL, while i_Rst_n=0, asynchronously force state IDLE, the synchronizer flops and counters to 0, and o_LinkUp_En=0, o_Clear_TimeOut=0, o_Remote_Rst_n=1, o_Link_Ok=0, o_Fault=0, o_Retry_Cnt=0 and o_State=IDLE.
REQ-031 SHALL, on reset deassertion mid-operation, restart from IDLE with no residual pulse on any output.

Structure
REQ-032 SHALL take the state encodings and parameter defaults from a shared package/include named linkup_pkg.
REQ-033 SHALL instantiate one sub-module, sync_2ff, as the i_ich_linkup synchronizer; all other logic stays flat.

Verification
REQ-034 SHALL verify reset: hold i_Rst_n=0 with random inputs -> all outputs at REQ-030 values; after release with i_Start=0 -> they stay there.
REQ-035 SHALL verify normal link-up: i_Start=1 -> o_LinkUp_En high 4 cycles, low 16 cycles, repeating; i_ich_linkup=1 during the 2nd GAP -> o_Link_Ok=1 at edge 3, one o_Clear_TimeOut pulse, o_LinkUp_En=0.
REQ-036 SHALL verify one recovery: i_TimeOut=1 in PULSE -> 1-cycle o_Clear_TimeOut, o_Remote_Rst_n low exactly 8 cycles, o_Retry_Cnt=1, then PULSE resumes.
REQ-037 SHALL verify fault: three consecutive timeouts -> o_Fault=1, o_Retry_Cnt=3, o_LinkUp_En=0 held; i_Start=0 -> IDLE next edge, o_Retry_Cnt=0.
REQ-038 SHALL verify simultaneous events: lk=1 and i_TimeOut=1 in the same cycle -> UP (not RECOVER); later i_ich_linkup=0 in UP -> RECOVER with o_Retry_Cnt incrementing.
REQ-039 SHALL verify abort: i_Start=0 on cycle 4 of RECOVER -> IDLE on the next edge and o_Remote_Rst_n=1 immediately.
